mux_sel_scanner: RTL and testbench

Sequential front-end that drives the select lines of the team's 8x1 behavioural mux. It walks the select index 0..7, waits a settle time at each index, and samples the mux output y back into an 8-bit capture register. The result is a parallel-to-serial-to-parallel readback of the mux's eight data inputs. A start/busy/done handshake connects it to upstream control logic.

---
 rtl/mux_sel_scanner_if.sv | 34 +++
 rtl/mux_sel_scanner.sv | 122 ++++++++++++
 tb/tb_mux_sel_scanner.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_scanner_if.sv
// Bus between mux_sel_scanner and its surroundings: the start/busy/done
// handshake, the mux select lines, the mux output fed back and the
// captured word. parity_out exists only when SCAN_PARITY_EN is defined.
interface mux_sel_scanner_if;
  logic       start;
  logic       y_in;
  logic       s0;
  logic       s1;
  logic       s2;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
`ifdef SCAN_PARITY_EN
  logic       parity_out;

  modport slave (
    input  start, y_in,
    output s0, s1, s2, busy, done, data_out, parity_out
  );
  modport master (
    output start, y_in,
    input  s0, s1, s2, busy, done, data_out, parity_out
  );
`else
  modport slave (
    input  start, y_in,
    output s0, s1, s2, busy, done, data_out
  );
  modport master (
    output start, y_in,
    input  s0, s1, s2, busy, done, data_out
  );
`endif
endinterface

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: walks an 8x1 mux select index 0..7, holds each index
// for DWELL settle cycles, samples the mux output once per index and
// presents the eight samples as data_out with a one-cycle done pulse.
// Optional macro SCAN_PARITY_EN adds parity_out (XOR of the captured word).
module mux_sel_scanner #(
  parameter int unsigned DWELL = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_scanner_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Counter reload: SETTLE runs while the counter walks DWELL-1 down to 0.
  localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
`ifdef SCAN_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // State register; every flop returns to zero on reset, including data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 8'h00;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
`ifdef SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      done_q   <= done_d;
`ifdef SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic: settle, sample, advance index, publish on the last one.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    done_d   = 1'b0;
`ifdef SCAN_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETTLE;
          idx_d   = 3'd0;
          cnt_d   = CNT_LOAD;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        shadow_d[idx_q] = bus.y_in;
        if (idx_q != 3'd7) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end else begin
          // idx stays at 7 through FINISH rather than wrapping to 0.
          state_d = FINISH;
        end
      end
      FINISH: begin
        data_d  = shadow_q;
        done_d  = 1'b1;
`ifdef SCAN_PARITY_EN
        parity_d = ^shadow_q;
`endif
        idx_d   = 3'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Select lines come straight from the index register: no input-to-select path.
  assign bus.s0       = idx_q[2];
  assign bus.s1       = idx_q[1];
  assign bus.s2       = idx_q[0];
  // busy covers the whole scan plus the done cycle that follows FINISH.
  assign bus.busy     = (state_q != IDLE) || done_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_q;
`ifdef SCAN_PARITY_EN
  assign bus.parity_out = parity_q;
`endif

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Bench for mux_sel_scanner (DWELL=2): a behavioural 8x1 mux closes the
// loop from the select lines to y_in; directed scans push their expected
// word and done cycle into a queue that a done-triggered monitor drains.
module tb_mux_sel_scanner;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_sel_scanner_if bus ();

  mux_sel_scanner #(.DWELL(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   scan_e0 = -1000000;
  logic [7:0] mux_in;
  logic       glitch_en;
  logic       noise = 1'b0;
  logic       settle_ph;
  int         off;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) noise <= ~noise;

  // Mux model; optional noise only in the SETTLE cycles of the current scan.
  always_comb begin
    off       = cyc - scan_e0;
    settle_ph = (off >= 0) && (off < 24) && ((off % 3) != 2);
    bus.y_in  = mux_in[{bus.s0, bus.s1, bus.s2}] ^ (glitch_en & settle_ph & noise);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] sel();
    return {bus.s0, bus.s1, bus.s2};
  endfunction

  // Monitor: every done must match the oldest expected scan.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
        chk("done_cycle", cyc, e.at);
        chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
`ifdef SCAN_PARITY_EN
        chk("parity_out", {31'd0, bus.parity_out}, {31'd0, ^e.data});
`endif
      end
    end
  end

  // Issue a one-cycle start; returns with scan_e0 set at the first SETTLE cycle.
  task automatic start_scan(input logic [7:0] pattern, input bit expect_done,
                            input logic [7:0] exp_word);
    mux_in    = pattern;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    scan_e0   = cyc;
    if (expect_done) q.push_back('{exp_word, cyc + 25});
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    mux_in    = 8'h00;
    glitch_en = 1'b0;

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_sel", {29'd0, sel()}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_data", {24'd0, bus.data_out}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_sel", {29'd0, sel()}, 32'd0);

    // Basic scan: i0..i7 = 0,1,0,1,0,1,0,1 -> 8'hAA; stray start mid-scan ignored
    start_scan(8'hAA, 1'b1, 8'hAA);
    for (int o = 0; o < 24; o++) begin
      chk("scan_sel", {29'd0, sel()}, o / 3);
      chk("scan_busy", {31'd0, bus.busy}, 32'd1);
      chk("scan_nodone", {31'd0, bus.done}, 32'd0);
      bus.start = (o == 5);
      @(negedge clk);
    end
    chk("finish_sel", {29'd0, sel()}, 32'd7);
    chk("finish_busy", {31'd0, bus.busy}, 32'd1);
    chk("finish_data_held", {24'd0, bus.data_out}, 32'd0);
    repeat (2) @(negedge clk);
    chk("post_busy", {31'd0, bus.busy}, 32'd0);
    chk("post_data", {24'd0, bus.data_out}, 32'hAA);
    chk("post_sel", {29'd0, sel()}, 32'd0);
    repeat (3) @(negedge clk);

    // Back-to-back: start held; inputs become 1,1,1,1,0,0,0,0 in FINISH
    mux_in    = 8'hAA;
    bus.start = 1'b1;
    @(negedge clk);
    scan_e0 = cyc;
    q.push_back('{8'hAA, cyc + 25});
    q.push_back('{8'h0F, cyc + 51});
    repeat (24) @(negedge clk);
    mux_in = 8'h0F;
    repeat (6) @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("b2b_data", {24'd0, bus.data_out}, 32'h0F);
    chk("b2b_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);

    // Reset mid-scan at index 4: no done, data_out cleared asynchronously
    start_scan(8'hFF, 1'b0, 8'h00);
    begin
      int n = 0;
      while (sel() != 3'd4 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("reach_idx4", {29'd0, sel()}, 32'd4);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", {29'd0, sel()}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_data", {24'd0, bus.data_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst_data_after", {24'd0, bus.data_out}, 32'd0);

    // Full scan after reset: i0..i7 = 1,1,1,0,0,0,0,0 -> 8'h07
    start_scan(8'h07, 1'b1, 8'h07);
    repeat (28) @(negedge clk);

    // Glitch rejection: y_in toggles in SETTLE, stable in SAMPLE -> 8'h5C
    glitch_en = 1'b1;
    start_scan(8'h5C, 1'b1, 8'h5C);
    repeat (28) @(negedge clk);
    glitch_en = 1'b0;

    // Drain the scoreboard with a bounded wait
    begin
      int n = 0;
      while (q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("scoreboard_empty", q.size(), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
